nios2_uart_tx_ctrl: RTL and testbench
=====================================

NIOS2_UART_TX_CTRL -- requirements
Module: nios2_uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DEFAULT_DIV, default 433, meaning the reset value of DIVISOR (50 MHz / 115200 baud, minus 1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of TX FIFO entries (power of 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port address, input, 2, Avalon-MM slave register select.
REQ-006 SHALL have port chipselect, input, 1, slave select.
REQ-007 SHALL have port write_n, input, 1, active-low write strobe.
REQ-008 SHALL have port writedata, input, 32, write data.
REQ-009 SHALL have port readdata, output, 32, combinational read data for the addressed register.
REQ-010 SHALL have port txd, output, 1, serial line (idle high).
REQ-011 SHALL have port irq, output, 1, interrupt: CONTROL.ien AND FIFO empty AND FSM idle.

Function
REQ-012 SHALL decode a write when chipselect=1, write_n=0.
REQ-013 SHALL map address 0 to TXDATA: a write pushes writedata[7:0] into the FIFO; a read returns 0.
REQ-014 SHALL map address 1 to STATUS (read): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count; write 1 to bit3 clears overflow.
REQ-015 SHALL map address 2 to DIVISOR, 16 bits R/W in [15:0]; upper bits read 0.
REQ-016 SHALL map address 3 to CONTROL R/W: bit0 enable, bit1 parity_en, bit2 parity_odd, bit3 ien; others read 0.
REQ-017 SHALL drop a TXDATA write when the FIFO is full at that edge, even if a pop happens on the same edge, and shall set overflow.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with enable=1 and FIFO non-empty, SHALL pop one byte, latch DIVISOR and CONTROL parity bits, and enter START on the next edge.
REQ-020 SHALL hold each bit for (latched DIVISOR + 1) clk cycles, using a down-counter reloaded at each bit boundary.
REQ-021 SHALL send START as txd=0, then DATA as 8 bits LSB first, then PARITY only if parity_en (even: XOR of data; odd: its inverse), then STOP as txd=1 for one bit time.
REQ-022 On STOP completion SHALL pop the next byte and go directly to START if enable=1 and the FIFO is non-empty, giving no idle gap; otherwise it SHALL return to IDLE.
REQ-023 SHALL apply DIVISOR and parity changes made mid-frame only at the next frame start.
REQ-024 When enable is cleared mid-frame, SHALL complete the current frame and then idle; queued bytes are retained.
REQ-025 SHALL register txd. With the FSM idle, txd SHALL fall on the second rising edge after the accepted TXDATA write.
REQ-026 SHALL produce a frame of 10 bits, or 11 with parity, times (DIV+1) cycles; DIV=0 SHALL be legal (1-cycle bits).

Reset
REQ-027 On reset, outputs and state SHALL be: txd=1, irq=0, FSM=IDLE, FIFO empty, overflow=0, DIVISOR=DEFAULT_DIV, CONTROL=0.
REQ-028 Reset asserted mid-frame SHALL force txd=1 immediately (asynchronously) and discard the partial frame and the FIFO contents.

Structure
REQ-029 SHALL place the FSM state encoding, register address constants and STATUS/CONTROL bit indices in shared package nios2_uart_tx_pkg.
REQ-030 SHALL implement the FIFO as sub-module nios2_uart_tx_fifo with push/pop/full/empty/count ports; the rest of the block is flat.

Verification
REQ-031 SHALL cover: DIV=3, CONTROL=1, write 0x55 -> txd low 2 edges later; bits 0,1,0,1,0,1,0,1,0,1 each 4 cycles; busy drops after 40 cycles.
REQ-032 SHALL cover: parity_en=1, parity_odd=0, byte 0x07 -> parity bit 1; parity_odd=1 -> parity bit 0; frame length 11 bit times.
REQ-033 SHALL cover: 5 writes with enable=0 -> count=4, full=1, overflow=1; then enable=1 -> 4 back-to-back frames with no idle gap, and irq=1 (with ien=1) after the last STOP.
REQ-034 SHALL cover: write DIV 3->7 during the DATA state -> the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
REQ-035 SHALL cover: assert reset during bit 4 of DATA -> txd=1 with no clock edge; after release STATUS=0x04 and DIVISOR=433.
REQ-036 SHALL cover: write 1 to STATUS bit3 -> overflow=0; DIV=0 -> each bit lasts exactly 1 cycle.

Source files
------------

// File: rtl/nios2_uart_tx_pkg.sv
// Shared constants for the Nios II style UART transmitter.
// FSM encoding, register map and STATUS/CONTROL bit positions.
package nios2_uart_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  localparam int CTL_EN   = 0;
  localparam int CTL_PEN  = 1;
  localparam int CTL_PODD = 2;
  localparam int CTL_IEN  = 3;

  function automatic logic parity_bit(
    input logic [7:0] d,
    input logic       odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/nios2_uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// A push while full is dropped even if a pop happens on the same edge.
module nios2_uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [7:0]    i_din,
  input  logic          i_pop,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/nios2_uart_tx_ctrl.sv
// Avalon-MM UART transmitter: register file, TX FIFO and bit FSM.
// Divisor and parity are latched per frame; txd is registered.
module nios2_uart_tx_ctrl
  import nios2_uart_tx_pkg::*;
#(
  parameter int DEFAULT_DIV = 433,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   r_div;
  logic          r_en;
  logic          r_pen;
  logic          r_podd;
  logic          r_ien;
  logic          r_ovf;
  logic [2:0]    r_state;
  logic [15:0]   r_cnt;
  logic [15:0]   r_bdiv;
  logic          r_fpen;
  logic          r_fpar;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit;
  logic          r_txd;

  logic          w_wr;
  logic          w_wr_tx;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [3:0]    w_cnt4;
  logic [7:0]    w_dout;
  logic          w_busy;
  logic          w_tick;
  logic          w_start;
  logic          w_pop;
  logic          w_txd_nx;
  logic          w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wr_tx  = w_wr & (address == ADDR_TXDATA);
  assign w_busy   = (r_state != ST_IDLE);
  assign w_tick   = (r_cnt == 16'd0);
  assign w_start  = r_en & ~w_empty;
  assign w_pop    = w_start &
                    ((r_state == ST_IDLE) |
                     ((r_state == ST_STOP) & w_tick));
  assign w_cnt4   = 4'(w_count);
  assign w_unused = &{1'b0, writedata[31:16]};

  nios2_uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr_tx),
    .i_din   (writedata[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= 16'(DEFAULT_DIV);
      r_en   <= 1'b0;
      r_pen  <= 1'b0;
      r_podd <= 1'b0;
      r_ien  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_wr) begin
      case (address)
        ADDR_TXDATA:  if (w_full) r_ovf <= 1'b1;
        ADDR_STATUS:  if (writedata[STAT_OVF]) r_ovf <= 1'b0;
        ADDR_DIVISOR: r_div <= writedata[15:0];
        default: begin
          r_en   <= writedata[CTL_EN];
          r_pen  <= writedata[CTL_PEN];
          r_podd <= writedata[CTL_PODD];
          r_ien  <= writedata[CTL_IEN];
        end
      endcase
    end
  end

  // A pop starts a frame from IDLE or straight out of STOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bdiv  <= '0;
      r_fpen  <= 1'b0;
      r_fpar  <= 1'b0;
      r_shift <= '0;
      r_bit   <= '0;
    end else if (w_pop) begin
      r_state <= ST_START;
      r_cnt   <= r_div;
      r_bdiv  <= r_div;
      r_fpen  <= r_pen;
      r_fpar  <= parity_bit(w_dout, r_podd);
      r_shift <= w_dout;
      r_bit   <= '0;
    end else if (w_busy) begin
      if (!w_tick) begin
        r_cnt <= r_cnt - 16'd1;
      end else begin
        r_cnt <= r_bdiv;
        case (r_state)
          ST_START: r_state <= ST_DATA;
          ST_DATA: begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7)
              r_state <= r_fpen ? ST_PARITY : ST_STOP;
          end
          ST_PARITY: r_state <= ST_STOP;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_txd_nx = 1'b1;
    case (r_state)
      ST_START:  w_txd_nx = 1'b0;
      ST_DATA:   w_txd_nx = r_shift[0];
      ST_PARITY: w_txd_nx = r_fpar;
      default:   w_txd_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_txd <= 1'b1;
    else       r_txd <= w_txd_nx;
  end

  assign txd = r_txd;
  assign irq = r_ien & w_empty & ~w_busy;

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: begin
        readdata[STAT_BUSY]  = w_busy;
        readdata[STAT_FULL]  = w_full;
        readdata[STAT_EMPTY] = w_empty;
        readdata[STAT_OVF]   = r_ovf;
        readdata[7:4]        = w_cnt4;
      end
      ADDR_DIVISOR: readdata[15:0] = r_div;
      ADDR_CONTROL: begin
        readdata[CTL_EN]   = r_en;
        readdata[CTL_PEN]  = r_pen;
        readdata[CTL_PODD] = r_podd;
        readdata[CTL_IEN]  = r_ien;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios2_uart_tx_ctrl.sv
// Directed bench for nios2_uart_tx_ctrl.
// Expected line levels are queued per byte and checked cycle by cycle.
module tb_nios2_uart_tx_ctrl;

  typedef struct {
    logic v;
    int   len;
  } bit_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        txd;
  logic        irq;

  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;
  int   t_rise = 0;
  int   t_fall = 0;
  logic pb = 1'b0;
  bit_t exq[$];

  nios2_uart_tx_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .txd        (txd),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (address == 2'd1 && write_n) begin
      if (readdata[0] && !pb) t_rise <= cyc;
      if (!readdata[0] && pb) t_fall <= cyc;
      pb <= readdata[0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    #1;
    address = a;
    #1;
    d = readdata;
    address = 2'd1;
  endtask

  task automatic push_frame(input logic [7:0] b, input int div,
                            input logic pen, input logic podd);
    bit_t e;
    e.len = div + 1;
    e.v = 1'b0;
    exq.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.v = b[i];
      exq.push_back(e);
    end
    if (pen) begin
      e.v = (^b) ^ podd;
      exq.push_back(e);
    end
    e.v = 1'b1;
    exq.push_back(e);
  endtask

  task automatic run_frames(input int budget);
    int t;
    bit_t e;
    logic [31:0] s;
    t = 0;
    while (txd !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("frame_start", 32'(txd), 32'd0);
    if (txd !== 1'b0) begin
      exq.delete();
      return;
    end
    while (exq.size() > 0) begin
      e = exq.pop_front();
      for (int k = 0; k < e.len; k++) begin
        chk("txd_bit", 32'(txd), 32'(e.v));
        @(negedge clk);
      end
    end
    chk("idle_txd", 32'(txd), 32'd1);
    rd(2'd1, s);
    chk("idle_busy", 32'(s[0]), 32'd0);
  endtask

  logic [31:0] s;

  initial begin
    address    = 2'd1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    rd(2'd1, s); chk("rst_status", s, 32'h04);
    rd(2'd2, s); chk("rst_div", s, 32'd433);
    rd(2'd3, s); chk("rst_ctrl", s, 32'd0);
    rd(2'd0, s); chk("txdata_rd", s, 32'd0);

    // 0x55 at DIV=3: latency, bit pattern, busy length
    wr(2'd2, 32'd3);
    wr(2'd3, 32'h1);
    rd(2'd2, s); chk("div_rb", s, 32'd3);
    rd(2'd3, s); chk("ctrl_rb", s, 32'd1);
    push_frame(8'h55, 3, 1'b0, 1'b0);
    wr(2'd0, 32'h55);
    @(negedge clk);
    chk("lat_edge1", 32'(txd), 32'd1);
    @(negedge clk);
    chk("lat_edge2", 32'(txd), 32'd0);
    run_frames(100);
    chk("busy_len", 32'(t_fall - t_rise), 32'd40);
    rd(2'd1, s); chk("status_done", s, 32'h04);

    // parity even then odd on 0x07
    wr(2'd3, 32'h3);
    push_frame(8'h07, 3, 1'b1, 1'b0);
    wr(2'd0, 32'h07);
    run_frames(100);
    wr(2'd3, 32'h7);
    push_frame(8'h07, 3, 1'b1, 1'b1);
    wr(2'd0, 32'h07);
    run_frames(100);

    // overflow with enable=0, then back-to-back drain
    wr(2'd3, 32'h8);
    chk("irq_idle", 32'(irq), 32'd1);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'hA0 + 32'(i));
    rd(2'd1, s); chk("status_full", s, 32'h4A);
    chk("irq_nonempty", 32'(irq), 32'd0);
    for (int i = 0; i < 4; i++)
      push_frame(8'hA0 + 8'(i), 3, 1'b0, 1'b0);
    wr(2'd3, 32'h9);
    run_frames(100);
    chk("irq_after", 32'(irq), 32'd1);
    rd(2'd1, s); chk("status_ovf", s, 32'h0C);
    wr(2'd1, 32'h8);
    rd(2'd1, s); chk("ovf_clear", s, 32'h04);

    // divisor change mid-frame applies to next frame only
    wr(2'd3, 32'h1);
    push_frame(8'h33, 3, 1'b0, 1'b0);
    push_frame(8'h3C, 7, 1'b0, 1'b0);
    wr(2'd0, 32'h33);
    wr(2'd0, 32'h3C);
    fork
      run_frames(100);
      begin
        repeat (10) @(negedge clk);
        wr(2'd2, 32'd7);
      end
    join
    rd(2'd2, s); chk("div7_rb", s, 32'd7);

    // reset during data bit 4
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h0F);
    wr(2'd0, 32'hAA);
    repeat (21) @(negedge clk);
    chk("pre_rst_txd", 32'(txd), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_txd", 32'(txd), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(2'd1, s); chk("post_rst_status", s, 32'h04);
    rd(2'd2, s); chk("post_rst_div", s, 32'd433);
    rd(2'd3, s); chk("post_rst_ctrl", s, 32'd0);
    chk("post_rst_irq", 32'(irq), 32'd0);
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(txd), 32'd1);

    // DIV=0: one-cycle bits
    wr(2'd2, 32'd0);
    wr(2'd3, 32'h1);
    push_frame(8'hA6, 0, 1'b0, 1'b0);
    wr(2'd0, 32'hA6);
    run_frames(50);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
